// File: rtl/call_stack.sv
// call_stack: return-address stack driving the PC load/nxt_adr pair.
// Optional CALL_STACK_WRAP_EN: a call while full overwrites the oldest entry.
module call_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     jmp,
    input  logic                     clr_err,
    input  logic [WIDTH-1:0]         target,
    input  logic [WIDTH-1:0]         crnt_adr,
    output logic                     load,
    output logic [WIDTH-1:0]         nxt_adr,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    sp_q, sp_d;
    logic [AW:0]      depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full_w, empty_w;
    logic             push, pop, set_ovf, set_unf;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] ret_adr;

    assign full_w  = (depth_q == DEPTH_C);
    assign empty_w = (depth_q == '0);
    assign top_idx = sp_q - AW'(1);
    assign ret_adr = crnt_adr + WIDTH'(1);

    // Decode requests in call > ret > jmp order into PC load and stack moves
    always_comb begin
        load    = 1'b0;
        nxt_adr = '0;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (reset) begin
            priority case (1'b1)
                call: begin
                    if (!full_w) begin
                        load    = 1'b1;
                        nxt_adr = target;
                        push    = 1'b1;
                    end else begin
`ifdef CALL_STACK_WRAP_EN
                        load    = 1'b1;
                        nxt_adr = target;
                        push    = 1'b1;
`else
                        set_ovf = 1'b1;
`endif
                    end
                end
                ret: begin
                    if (!empty_w) begin
                        load    = 1'b1;
                        nxt_adr = mem_q[top_idx];
                        pop     = 1'b1;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
                jmp: begin
                    load    = 1'b1;
                    nxt_adr = target;
                end
                default: ;
            endcase
        end
    end

    // Next pointer, count and sticky flags; a new error beats clr_err
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        if (push) begin
            sp_d = sp_q + AW'(1);
            if (!full_w)
                depth_d = depth_q + (AW+1)'(1);
        end else if (pop) begin
            sp_d    = top_idx;
            depth_d = depth_q - (AW+1)'(1);
        end
        ovf_d = set_ovf | (ovf_q & ~clr_err);
        unf_d = set_unf | (unf_q & ~clr_err);
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage, not reset; contents are hidden while empty
    always_ff @(posedge clk) begin
        if (push)
            mem_q[sp_q] <= ret_adr;
    end

    assign depth     = depth_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
